// File: rtl/grey_to_bin_tracker_pkg.sv
// Shared types and helpers for the Grey-to-binary tracker: FSM state encoding,
// error-counter width and a generic Grey-to-binary conversion function.
package grey_to_bin_tracker_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

   localparam int ERR_CNT_W = 8;

   // Zero-extended inputs convert correctly: leading zeros leave the prefix XOR unchanged.
   function automatic logic [31:0] grey2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/grey_to_bin_tracker_sync.sv
// Reset-able SYNC_STAGES-deep flop chain bringing an asynchronous Grey bus into clk.
module grey_to_bin_tracker_sync #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [SYNC_STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/grey_to_bin_tracker.sv
// Grey-coded pointer receiver: synchronize, convert to binary, classify steps.
// Optional saturating illegal-jump counter on err_cnt when GREY_ERR_CNT_EN is defined.
//
// state    | meaning
// ST_INIT  | no reference sample yet; first enabled sample loads without err
// ST_TRACK | compare each synchronized sample against the last accepted one
module grey_to_bin_tracker
   import grey_to_bin_tracker_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [WIDTH-1:0]     g_in,
   output logic [WIDTH-1:0]     b_out,
   output logic                 b_valid,
   output logic                 dir,
   output logic                 wrap,
`ifdef GREY_ERR_CNT_EN
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
`else
   output logic                 err
`endif
);

   logic [WIDTH-1:0] g_s;
   logic [WIDTH-1:0] g_prev;
   logic [WIDTH-1:0] b_conv;
   logic [WIDTH-1:0] diff;
   logic             changed;
   logic             single_bit;
   logic             step_up;
   logic             step_wrap;
   state_t           state;

   grey_to_bin_tracker_sync #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (g_in),
      .q  (g_s)
   );

   assign b_conv     = WIDTH'(grey2bin(32'(g_s)));
   assign diff       = g_s ^ g_prev;
   assign changed    = (diff != '0);
   assign single_bit = ((diff & (diff - WIDTH'(1))) == '0);
   assign step_up    = (b_conv == b_out + WIDTH'(1));
   assign step_wrap  = ((b_out == '1) && (b_conv == '0)) || ((b_out == '0) && (b_conv == '1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_INIT;
         g_prev  <= '0;
         b_out   <= '0;
         b_valid <= 1'b0;
         dir     <= 1'b0;
         wrap    <= 1'b0;
         err     <= 1'b0;
`ifdef GREY_ERR_CNT_EN
         err_cnt <= '0;
`endif
      end else begin
         b_valid <= 1'b0;
         wrap    <= 1'b0;
         err     <= 1'b0;
         case (state)
            ST_INIT: begin
               if (en) begin
                  b_out   <= b_conv;
                  g_prev  <= g_s;
                  b_valid <= 1'b1;
                  dir     <= 1'b0;
                  state   <= ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (en && changed) begin
                  b_out   <= b_conv;
                  g_prev  <= g_s;
                  b_valid <= 1'b1;
                  if (single_bit) begin
                     dir  <= step_up;
                     wrap <= step_wrap;
                  end else begin
                     // Multi-bit jump: resync to the new value, keep the last direction.
                     err <= 1'b1;
`ifdef GREY_ERR_CNT_EN
                     if (err_cnt != '1) begin
                        err_cnt <= err_cnt + ERR_CNT_W'(1);
                     end
`endif
                  end
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_grey_to_bin_tracker.sv
// Scoreboard bench for grey_to_bin_tracker: random and directed Grey stimulus
// against a value-level reference model; monitor pops expectations on b_valid.
module tb_grey_to_bin_tracker;

   localparam int W = 4;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [W-1:0] g_in;
   logic [W-1:0] b_out;
   logic         b_valid;
   logic         dir;
   logic         wrap;
   logic         err;
`ifdef GREY_ERR_CNT_EN
   logic [7:0]   err_cnt;
`endif

   grey_to_bin_tracker #(.WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .g_in   (g_in),
      .b_out  (b_out),
      .b_valid(b_valid),
      .dir    (dir),
      .wrap   (wrap),
`ifdef GREY_ERR_CNT_EN
      .err    (err),
      .err_cnt(err_cnt)
`else
      .err    (err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int b;
      int d;
      int w;
      int e;
      int c;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   // Reference model state, in plain integers
   int   bin_of[N];
   bit   m_init;
   int   m_prev;
   int   m_dir;
   int   m_cnt;
   int   cur_bin;

   task automatic chk(input bit ok, input string name, input int act, input int expv);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, expv);
   endtask

   function automatic int enc(input int b);
      return (b ^ (b >> 1)) & (N - 1);
   endfunction

   // Evaluate the model against a settled, enabled Grey value
   task automatic model_eval(input int g);
      exp_t x;
      int   ob, nb;
      nb = bin_of[g];
      if (m_init) begin
         m_init = 1'b0;
         m_dir  = 0;
         m_prev = g;
         x = '{b: nb, d: 0, w: 0, e: 0, c: m_cnt};
         sb.push_back(x);
      end else if (g != m_prev) begin
         ob = bin_of[m_prev];
         if ($countones(g ^ m_prev) == 1) begin
            m_dir = (nb == (ob + 1) % N) ? 1 : 0;
            x = '{b: nb, d: m_dir, w: ((ob == N-1 && nb == 0) || (ob == 0 && nb == N-1)) ? 1 : 0,
                  e: 0, c: m_cnt};
         end else begin
            if (m_cnt < 255) m_cnt++;
            x = '{b: nb, d: m_dir, w: 0, e: 1, c: m_cnt};
         end
         m_prev = g;
         sb.push_back(x);
      end
   endtask

   task automatic step_bin(input int b);
      cur_bin = b % N;
      g_in = W'(enc(cur_bin));
      if (en) model_eval(enc(cur_bin));
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic set_en(input bit v);
      en = v;
      if (v) model_eval(enc(cur_bin));
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(sb.size() == 0, name, sb.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (!rst) begin
         if (b_valid) begin
            if (sb.size() == 0) begin
               chk(1'b0, "unexpected_valid", int'(b_out), -1);
            end else begin
               x = sb.pop_front();
               chk(int'(b_out) == x.b, "b_out", int'(b_out), x.b);
               chk(int'(dir)   == x.d, "dir",   int'(dir),   x.d);
               chk(int'(wrap)  == x.w, "wrap",  int'(wrap),  x.w);
               chk(int'(err)   == x.e, "err",   int'(err),   x.e);
`ifdef GREY_ERR_CNT_EN
               chk(int'(err_cnt) == x.c, "err_cnt", int'(err_cnt), x.c);
`endif
            end
         end else begin
            chk((wrap | err) == 1'b0, "stray_pulse", int'({wrap, err}), 0);
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) bin_of[enc(i)] = i;

      // Reset with en=1, g=0: one reload of 0, no err
      rst = 1'b1; en = 1'b1; g_in = '0; cur_bin = 0;
      m_init = 1'b1; m_prev = 0; m_dir = 0; m_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      chk(b_out == '0 && b_valid == 1'b0 && dir == 1'b0, "reset_state", int'(b_out), 0);
      model_eval(0);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      drain("init_load");

      // Upward walk including 15 -> 0 wrap, then back down across the wrap
      for (int i = 1; i <= 16; i++) step_bin(i);
      step_bin(15);
      // 2 -> 1 down step
      step_bin(1); step_bin(2); step_bin(1);
      // 0 -> 2 (g 0000 -> 0011) illegal jump
      step_bin(0); step_bin(2);
      drain("directed");

      // Changes while disabled are reported against the frozen reference
      step_bin(0);
      set_en(1'b0);
      step_bin(1); step_bin(2);
      set_en(1'b1);
      drain("reenable");

      // Randomized walk
      for (int k = 0; k < 250; k++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 5)      step_bin(cur_bin + 1);
         else if (r <= 7) step_bin(cur_bin + N - 1);
         else if (r == 8) step_bin($urandom_range(0, N-1));
         else             set_en(~en);
      end
      if (!en) set_en(1'b1);
      drain("random");

      // 300 alternating illegal jumps saturate the counter
      for (int k = 0; k < 300; k++) step_bin((k % 2 == 0) ? 0 : 2);
      drain("alternating");
`ifdef GREY_ERR_CNT_EN
      chk(err_cnt == 8'd255, "err_cnt_sat", int'(err_cnt), 255);
`endif

      // Reset mid-walk: outputs clear immediately, next enabled sample reloads cleanly
      step_bin(5); step_bin(6);
      drain("pre_reset");
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk(b_out == '0, "rst_b_out", int'(b_out), 0);
      chk(dir == 1'b0 && b_valid == 1'b0, "rst_flags", int'({dir, b_valid}), 0);
`ifdef GREY_ERR_CNT_EN
      chk(err_cnt == 8'd0, "rst_err_cnt", int'(err_cnt), 0);
`endif
      en = 1'b0;
      m_init = 1'b1; m_dir = 0; m_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      set_en(1'b1);
      step_bin(7); step_bin(9);
      drain("post_reset");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got %0d expected %0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
